// File: rtl/rs232out_fifo.sv
// rs232out_fifo: buffered UART transmitter. Words enter a FIFO through a
// valid/ready handshake and are serialised on tx as start, data (LSB first),
// optional parity and one or two stop bits. Frame format and baud divisor are
// captured when a word leaves the FIFO, so changes only affect later frames.
// Parity generation exists only when RS232OUT_FIFO_PARITY_EN is defined;
// otherwise parity_en and parity_odd are ignored.
module rs232out_fifo #(
    parameter int DATA_BITS       = 8,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int DIV_WIDTH       = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DIV_WIDTH-1:0]     divisor,
    input  logic                     stop2,
    input  logic                     parity_en,
    input  logic                     parity_odd,
    input  logic                     tx_data_valid,
    output logic                     tx_data_ready,
    input  logic [DATA_BITS-1:0]     tx_data,
    output logic                     tx,
    output logic                     busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level
);
    localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
    // start + up to 9 data + parity + 2 stop bits
    localparam int FRAME_W = DATA_BITS + 4;
    // longest frame is 13 bits, so 4 bits of bit counter suffice
    localparam int BIT_W   = 4;

    localparam logic [FIFO_DEPTH_LOG2:0]   LEVEL_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0]   LEVEL_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);
    localparam logic [BIT_W-1:0]           BITS_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]           BASE_BITS  = BIT_W'(DATA_BITS + 2);
    localparam logic [DIV_WIDTH-1:0]       DIV_ONE    = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0]       DIV_MIN    = DIV_WIDTH'(2);

    // state    | meaning
    // ST_IDLE  | line high, waiting for the FIFO to hold a word
    // ST_SHIFT | a frame is on the line; shift_q[0] is the current bit
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [FRAME_W-1:0]         shift_q, shift_d;
    logic [BIT_W-1:0]           bits_q, bits_d;
    logic [DIV_WIDTH-1:0]       baud_q, baud_d;
    logic [DIV_WIDTH-1:0]       div_q, div_d;

    logic [DATA_BITS-1:0]       mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   level_q, level_d;

    logic                       push;
    logic                       pop;
    logic                       fifo_empty;
    logic [DATA_BITS-1:0]       head_data;

    logic                       par_on;
    logic                       par_bit;
    logic [FRAME_W-1:0]         frame_new;
    logic [BIT_W-1:0]           len_new;
    logic [DIV_WIDTH-1:0]       div_new;

`ifndef RS232OUT_FIFO_PARITY_EN
    // parity inputs are kept on the port list but have no function here
    logic unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
`endif

    assign fifo_empty    = (level_q == '0);
    assign tx_data_ready = (level_q != LEVEL_FULL);
    assign push          = tx_data_valid & tx_data_ready;
    assign head_data     = mem_q[rd_ptr_q];

    // FIFO pointer and level next-state; a simultaneous push and pop leaves the level alone
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            level_d = level_q + LEVEL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LEVEL_ONE;
        end
    end

    // FIFO pointer and level registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents need no reset because the level gates every read
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // Assemble the frame, its bit count and clamped divisor for the word at the FIFO head
    always_comb begin
        par_on  = 1'b0;
        par_bit = 1'b0;
`ifdef RS232OUT_FIFO_PARITY_EN
        par_on  = parity_en;
        par_bit = (^head_data) ^ parity_odd;
`endif
        // unused upper positions stay 1 so they read as stop bits
        frame_new              = '1;
        frame_new[0]           = 1'b0;
        frame_new[DATA_BITS:1] = head_data;
        if (par_on) begin
            frame_new[DATA_BITS+1] = par_bit;
        end
        len_new = BASE_BITS + {{(BIT_W-1){1'b0}}, par_on} + {{(BIT_W-1){1'b0}}, stop2};
        div_new = (divisor < DIV_MIN) ? DIV_MIN : divisor;
    end

    // Shifter next-state: baud down-counter per bit, bit down-counter per frame
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bits_d  = bits_q;
        baud_d  = baud_q;
        div_d   = div_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - DIV_ONE;
                end else if (bits_q != BITS_ONE) begin
                    shift_d = {1'b1, shift_q[FRAME_W-1:1]};
                    bits_d  = bits_q - BITS_ONE;
                    baud_d  = div_q - DIV_ONE;
                end else if (!fifo_empty) begin
                    // chain straight into the next start bit, no idle gap
                    pop = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (pop) begin
            state_d = ST_SHIFT;
            shift_d = frame_new;
            bits_d  = len_new;
            baud_d  = div_new - DIV_ONE;
            div_d   = div_new;
        end
    end

    // Shifter registers; reset drops the frame and returns the line high at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '1;
            bits_q  <= '0;
            baud_q  <= '0;
            div_q   <= DIV_MIN;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
        end
    end

    assign tx         = (state_q == ST_SHIFT) ? shift_q[0] : 1'b1;
    assign busy       = (state_q == ST_SHIFT) | ~fifo_empty;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_rs232out_fifo.sv
// Bench for rs232out_fifo: directed scenarios plus a random phase, checked each
// cycle against a queue-based model that expands every popped word into its
// expected line waveform.
module tb_rs232out_fifo;
    localparam int DB    = 8;
    localparam int L     = 4;
    localparam int DEPTH = 1 << L;
`ifdef RS232OUT_FIFO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [15:0]   divisor = 16'd4;
    logic          stop2 = 1'b0;
    logic          parity_en = 1'b0;
    logic          parity_odd = 1'b0;
    logic          tx_data_valid = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_data_ready;
    logic          tx;
    logic          busy;
    logic [L:0]    fifo_level;

    int checks   = 0;
    int failures = 0;

    rs232out_fifo #(.DATA_BITS(DB), .FIFO_DEPTH_LOG2(L), .DIV_WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .divisor      (divisor),
        .stop2        (stop2),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready),
        .tx_data      (tx_data),
        .tx           (tx),
        .busy         (busy),
        .fifo_level   (fifo_level)
    );

    always #5 clock = ~clock;

    // model: queued words, and the line level expected after each coming edge
    logic [DB-1:0] m_fifo[$];
    bit            m_wave[$];
    bit            m_push;

    task automatic append_frame(input logic [DB-1:0] d);
        bit bits[$];
        int dv;
        dv = (divisor < 16'd2) ? 2 : int'(divisor);
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
`ifdef RS232OUT_FIFO_PARITY_EN
        if (parity_en) bits.push_back((^d) ^ parity_odd);
`endif
        bits.push_back(1'b1);
        if (stop2) bits.push_back(1'b1);
        foreach (bits[i]) repeat (dv) m_wave.push_back(bits[i]);
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_fifo.delete();
            m_wave.delete();
        end else begin
            m_push = tx_data_valid && (m_fifo.size() != DEPTH);
            if (m_wave.size() > 0) void'(m_wave.pop_front());
            if (m_wave.size() == 0 && m_fifo.size() > 0) append_frame(m_fifo.pop_front());
            if (m_push) m_fifo.push_back(tx_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        chk("tx", 32'(tx), 32'((m_wave.size() > 0) ? m_wave[0] : 1'b1));
        chk("busy", 32'(busy), 32'(m_wave.size() > 0 || m_fifo.size() > 0));
        chk("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
        chk("ready", 32'(tx_data_ready), 32'(m_fifo.size() != DEPTH));
    endtask

    bit samp[1024];

    task automatic run_idle(input int budget, output int n);
        n = budget;
        for (int k = 0; k < budget; k++) begin
            cycle();
            samp[k] = tx;
            if (busy === 1'b0) begin
                n = k;
                break;
            end
        end
        if (n == budget) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic push_one(input logic [DB-1:0] d);
        tx_data       = d;
        tx_data_valid = 1'b1;
        cycle();
        tx_data_valid = 1'b0;
    endtask

    initial begin
        int n;
        int low;
        logic [9:0] got;

        // asynchronous reset, observed before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ready", 32'(tx_data_ready), 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) cycle();

        // basic 8N1 frame at divisor 4
        divisor = 16'd4;
        push_one(8'h55);
        run_idle(200, n);
        chk("basic_len", 32'(n), 32'd40);
        for (int j = 0; j < 10; j++) got[j] = samp[j*4+2];
        chk("basic_bits", 32'(got), 32'h2AA);

        // parity (even, then odd) with two stop bits at divisor 2
        divisor = 16'd2; stop2 = 1'b1; parity_en = 1'b1; parity_odd = 1'b0;
        push_one(8'h07);
        run_idle(200, n);
        chk("par_even_len", 32'(n), 32'((11 + PAR) * 2));
        chk("par_even_bit", 32'(samp[19]), 32'd1);
        chk("par_even_stop", 32'(samp[(10 + PAR) * 2 + 1]), 32'd1);
        parity_odd = 1'b1;
        push_one(8'h07);
        run_idle(200, n);
        chk("par_odd_len", 32'(n), 32'((11 + PAR) * 2));
        chk("par_odd_bit", 32'(samp[19]), 32'((PAR == 1) ? 0 : 1));
        stop2 = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;

        // divisor switched mid-frame only affects the following frame
        divisor = 16'd8;
        tx_data = 8'hA3; tx_data_valid = 1'b1;
        cycle();
        tx_data = 8'h3D;
        cycle();
        tx_data_valid = 1'b0;
        repeat (40) cycle();
        divisor = 16'd3;
        run_idle(300, n);
        chk("divchg_len", 32'(n), 32'd69);
        chk("divchg_stop1", 32'(samp[38]), 32'd1);
        chk("divchg_start", 32'(samp[41]), 32'd0);
        chk("divchg_d0", 32'(samp[42]), 32'd1);

        // divisor clamp: 0 and 1 both give 2-cycle bits
        for (int dv = 0; dv < 2; dv++) begin
            divisor = 16'(dv);
            push_one(8'h81);
            run_idle(100, n);
            chk("clamp_len", 32'(n), 32'd20);
            chk("clamp_start", 32'(samp[1]), 32'd0);
            chk("clamp_d0", 32'(samp[2]), 32'd1);
        end

        // fill: 17 back-to-back pushes, then ready low, frames leave with no gap
        divisor = 16'd2;
        for (int i = 0; i < 17; i++) begin
            tx_data = 8'(i); tx_data_valid = 1'b1;
            cycle();
        end
        chk("fill_level", 32'(fifo_level), 32'd16);
        chk("fill_ready", 32'(tx_data_ready), 32'd0);
        tx_data = 8'hEE;
        repeat (3) cycle();
        tx_data_valid = 1'b0;
        cycle();
        chk("fill_ready_before_pop", 32'(tx_data_ready), 32'd0);
        cycle();
        chk("fill_ready_after_pop", 32'(tx_data_ready), 32'd1);
        run_idle(600, n);
        chk("fill_len", 32'(n), 32'd319);

        // reset during data bit 3 with 5 words queued
        divisor = 16'd4;
        for (int i = 0; i < 6; i++) begin
            tx_data = 8'(8'h40 + i); tx_data_valid = 1'b1;
            cycle();
        end
        tx_data_valid = 1'b0;
        chk("rstmid_level", 32'(fifo_level), 32'd5);
        repeat (13) cycle();
        #2 reset = 1'b1;
        #1;
        chk("rstmid_tx", 32'(tx), 32'd1);
        chk("rstmid_level0", 32'(fifo_level), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_ready", 32'(tx_data_ready), 32'd1);
        cycle();
        reset = 1'b0;
        low = 0;
        repeat (60) begin
            cycle();
            if (tx !== 1'b1) low++;
        end
        chk("rstmid_quiet", 32'(low), 32'd0);

        // random traffic with per-cycle format changes
        for (int r = 0; r < 400; r++) begin
            tx_data_valid = ($urandom_range(0, 3) == 0);
            tx_data       = 8'($urandom);
            divisor       = 16'($urandom_range(0, 4));
            stop2         = 1'($urandom);
            parity_en     = 1'($urandom);
            parity_odd    = 1'($urandom);
            cycle();
        end
        tx_data_valid = 1'b0;
        run_idle(1000, n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
